// File: rtl/axi_pkg.sv
// Shared AXI types, response codes and burst legality helpers for the burst slave memory.
package axi_pkg;

  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11} burst_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Whole-burst errors: wrong beat size, reserved burst type, or illegal wrap length.
  function automatic logic burst_bad(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len, input logic [2:0] size_ok);
    return (size != size_ok) || (burst == RSVD) || ((burst == WRAP) && !wrap_len_ok(len));
  endfunction

endpackage

// File: rtl/axi_burst_slave_mem_if.sv
// AXI4 channel signal set between a master and the burst slave memory.
interface axi_burst_slave_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] AWADDR, ARADDR;
  logic [7:0]            AWLEN, ARLEN;
  logic [2:0]            AWSIZE, ARSIZE;
  logic [1:0]            AWBURST, ARBURST;
  logic                  AWVALID, AWREADY, ARVALID, ARREADY;
  logic [DATA_WIDTH-1:0] WDATA, RDATA;
  logic [BYTES-1:0]      WSTRB;
  logic                  WLAST, WVALID, WREADY;
  logic [1:0]            BRESP, RRESP;
  logic                  BVALID, BREADY;
  logic                  RLAST, RVALID, RREADY;

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  WDATA, WSTRB, WLAST, WVALID, BREADY, RREADY,
    output AWREADY, ARREADY, WREADY, BRESP, BVALID, RDATA, RRESP, RLAST, RVALID
  );

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output WDATA, WSTRB, WLAST, WVALID, BREADY, RREADY,
    input  AWREADY, ARREADY, WREADY, BRESP, BVALID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_addr_gen.sv
// Combinational per-beat address step (FIXED/INCR/WRAP) plus word index and range check.
module axi_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int BYTES      = 4,
  parameter int MEM_DEPTH  = 1024,
  localparam int BLOG2     = $clog2(BYTES),
  localparam int MW        = $clog2(MEM_DEPTH)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  burst_t                burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic [MW-1:0]         widx,
  output logic                  in_range
);
  logic [ADDR_WIDTH-1:0] incr, wmask, word;
  logic [31:0]           span;

  always_comb begin
    incr     = addr + ADDR_WIDTH'(BYTES);
    span     = (32'(len) + 32'd1) << BLOG2;
    wmask    = ADDR_WIDTH'(span - 32'd1);
    word     = addr >> BLOG2;
    in_range = 32'(word) < 32'(MEM_DEPTH);
    widx     = word[MW-1:0];
    case (burst)
      INCR:    next_addr = incr;
      WRAP:    next_addr = (addr & ~wmask) | (incr & wmask);
      default: next_addr = addr;
    endcase
  end
endmodule

// File: rtl/axi_burst_slave_mem.sv
// AXI4 burst slave memory: independent read/write FSMs over one word array with byte strobes.
module axi_burst_slave_mem
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 1024
) (
  input logic                 clk,
  input logic                 rst,
  axi_burst_slave_mem_if.slave s
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BLOG2 = $clog2(BYTES);
  localparam int MW    = $clog2(MEM_DEPTH);
  localparam logic [2:0] SIZE_OK = 3'(BLOG2);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    burst_t                burst;
    logic [7:0]            beat;
    logic                  err;   // sticky response error
    logic                  skip;  // whole-burst error: no memory access
  } ctx_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  wstate_t w_state_q, w_state_d;
  ctx_t    wc_q, wc_d;
  logic    awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0] bresp_q, bresp_d;
  logic    mem_we, aw_bad;

  rstate_t r_state_q, r_state_d;
  ctx_t    rc_q, rc_d;
  logic    arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d, ar_bad;
  logic [1:0] rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [ADDR_WIDTH-1:0] w_next, r_next;
  logic [MW-1:0]         w_widx, r_widx;
  logic                  w_inr, r_inr;

  axi_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BYTES(BYTES), .MEM_DEPTH(MEM_DEPTH)) u_wgen (
    .addr(wc_q.addr), .len(wc_q.len), .burst(wc_q.burst),
    .next_addr(w_next), .widx(w_widx), .in_range(w_inr)
  );

  axi_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BYTES(BYTES), .MEM_DEPTH(MEM_DEPTH)) u_rgen (
    .addr(rc_q.addr), .len(rc_q.len), .burst(rc_q.burst),
    .next_addr(r_next), .widx(r_widx), .in_range(r_inr)
  );

  always_comb begin
    w_state_d = w_state_q;
    wc_d      = wc_q;
    mem_we    = 1'b0;
    aw_bad    = burst_bad(s.AWSIZE, s.AWBURST, s.AWLEN, SIZE_OK);
    case (w_state_q)
      W_IDLE: if (awready_q && s.AWVALID) begin
        wc_d.addr  = s.AWADDR & ~ADDR_WIDTH'(BYTES - 1);
        wc_d.len   = s.AWLEN;
        wc_d.burst = burst_t'(s.AWBURST);
        wc_d.beat  = '0;
        wc_d.err   = aw_bad;
        wc_d.skip  = aw_bad;
        w_state_d  = W_DATA;
      end
      W_DATA: if (wready_q && s.WVALID) begin
        // A beat racing an asserted reset is dropped along with the burst.
        mem_we = !rst && !wc_q.skip && w_inr;
        if (!w_inr || (s.WLAST != (wc_q.beat == wc_q.len))) wc_d.err = 1'b1;
        wc_d.addr = w_next;
        wc_d.beat = wc_q.beat + 8'd1;
        if (wc_q.beat == wc_q.len) w_state_d = W_RESP;
      end
      W_RESP: if (bvalid_q && s.BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
    bresp_d   = (bvalid_d && wc_d.err) ? RESP_SLVERR : RESP_OKAY;
  end

  always_comb begin
    r_state_d = r_state_q;
    rc_d      = rc_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    ar_bad    = burst_bad(s.ARSIZE, s.ARBURST, s.ARLEN, SIZE_OK);
    case (r_state_q)
      R_IDLE: if (arready_q && s.ARVALID) begin
        rc_d.addr  = s.ARADDR & ~ADDR_WIDTH'(BYTES - 1);
        rc_d.len   = s.ARLEN;
        rc_d.burst = burst_t'(s.ARBURST);
        rc_d.beat  = '0;
        rc_d.err   = ar_bad;
        rc_d.skip  = ar_bad;
        r_state_d  = R_FETCH;
      end
      R_FETCH: begin
        // Array read happens before this edge's write lands: read-before-write.
        rdata_d   = (rc_q.skip || !r_inr) ? '0 : mem[r_widx];
        rresp_d   = (rc_q.err || !r_inr) ? RESP_SLVERR : RESP_OKAY;
        rlast_d   = (rc_q.beat == rc_q.len);
        r_state_d = R_DATA;
      end
      R_DATA: if (rvalid_q && s.RREADY) begin
        rc_d.addr = r_next;
        rc_d.beat = rc_q.beat + 8'd1;
        rdata_d   = '0;
        rresp_d   = RESP_OKAY;
        rlast_d   = 1'b0;
        r_state_d = rlast_q ? R_IDLE : R_FETCH;
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      wc_q      <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      rc_q      <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      wc_q      <= wc_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      rc_q      <= rc_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s.WSTRB[b]) mem[w_widx][b*8 +: 8] <= s.WDATA[b*8 +: 8];
      end
    end
  end

  assign s.AWREADY = awready_q;
  assign s.WREADY  = wready_q;
  assign s.BVALID  = bvalid_q;
  assign s.BRESP   = bresp_q;
  assign s.ARREADY = arready_q;
  assign s.RVALID  = rvalid_q;
  assign s.RLAST   = rlast_q;
  assign s.RRESP   = rresp_q;
  assign s.RDATA   = rdata_q;
endmodule
